// File: rtl/exp_42.sv
// exp_42 : priority route selector with minimum-hold dwell timer.
//
// Three asynchronous presence sensors are synchronized, priority-encoded
// (sensor1 highest) and used to pick one of three routes. Once a route is
// selected it is held for at least MIN_HOLD clocks before a different
// request may take over. Leaving IDLE is immediate. The dwell counter g
// reports clocks since the last selection change and saturates.
//
// Parameters
//   MIN_HOLD     minimum dwell, in clocks, before a non-idle selection may change
//   SYNC_STAGES  synchronizer depth per sensor (2..4)
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-low reset
//   sensor1..sensor3    asynchronous presence inputs (1 = highest priority)
//   switch1..switch3    registered route selects, one-hot or all zero
//   g[31:0]             registered saturating dwell counter
module exp_42 #(
  parameter int MIN_HOLD    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor1,
  input  logic        sensor2,
  input  logic        sensor3,
  output logic        switch1,
  output logic        switch2,
  output logic        switch3,
  output logic [31:0] g
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL1 = 2'd1,
    ST_SEL2 = 2'd2,
    ST_SEL3 = 2'd3
  } state_t;

  localparam logic [31:0] HOLD = 32'(MIN_HOLD);

  logic [SYNC_STAGES-1:0] r_sync1;
  logic [SYNC_STAGES-1:0] r_sync2;
  logic [SYNC_STAGES-1:0] r_sync3;
  state_t                 r_state;
  logic [31:0]            r_g;
  logic                   r_sw1;
  logic                   r_sw2;
  logic                   r_sw3;

  logic                   w_s1;
  logic                   w_s2;
  logic                   w_s3;
  state_t                 w_req;
  state_t                 w_next;
  logic                   w_change;

  // Dwell counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Synchronizer stage: sensors shift in at bit 0, synced level at the MSB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= {r_sync1[SYNC_STAGES-2:0], sensor1};
      r_sync2 <= {r_sync2[SYNC_STAGES-2:0], sensor2};
      r_sync3 <= {r_sync3[SYNC_STAGES-2:0], sensor3};
    end
  end

  assign w_s1 = r_sync1[SYNC_STAGES-1];
  assign w_s2 = r_sync2[SYNC_STAGES-1];
  assign w_s3 = r_sync3[SYNC_STAGES-1];

  // Request encode and next-state selection.
  always_comb begin
    w_req    = ST_IDLE;
    w_next   = r_state;
    w_change = 1'b0;
    if (w_s1)      w_req = ST_SEL1;
    else if (w_s2) w_req = ST_SEL2;
    else if (w_s3) w_req = ST_SEL3;

    case (r_state)
      // Leaving IDLE is never subject to the dwell minimum.
      ST_IDLE: if (w_req != ST_IDLE) w_next = w_req;
      // Any differing request (including none) waits out the dwell minimum;
      // the target is whatever is requested on the edge the change happens.
      default: if ((w_req != r_state) && (r_g >= HOLD)) w_next = w_req;
    endcase
    w_change = (w_next != r_state);
  end

  // State, dwell counter and output register stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_sw1   <= 1'b0;
      r_sw2   <= 1'b0;
      r_sw3   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_g     <= w_change ? 32'd0 : sat_inc(r_g);
      r_sw1   <= (w_next == ST_SEL1);
      r_sw2   <= (w_next == ST_SEL2);
      r_sw3   <= (w_next == ST_SEL3);
    end
  end

  assign switch1 = r_sw1;
  assign switch2 = r_sw2;
  assign switch3 = r_sw3;
  assign g       = r_g;

endmodule

// File: tb/tb_exp_42.sv
// tb_exp_42 : self-checking bench for exp_42.
// Two instances share the sensor inputs: one with the default dwell of 10
// and one built with MIN_HOLD=0. Directed vectors and scenario sequences
// use hand-derived constants; a behavioural model tracks both instances on
// every edge, including a long randomized run.
module tb_exp_42;

  localparam int SYNC = 2;
  localparam int HOLD_A = 10;
  localparam int HOLD_B = 0;

  logic        clk;
  logic        rst;
  logic [2:0]  sens;  // {sensor3, sensor2, sensor1}

  logic        sw1a, sw2a, sw3a, sw1b, sw2b, sw3b;
  logic [31:0] ga, gb;
  logic [2:0]  swa, swb;

  int n_tests;
  int n_fail;

  // Behavioural model: delay line of sampled sensor vectors plus, per
  // instance, the selected route (0 = none) and the dwell count.
  logic [2:0] m_q[$];
  int         m_sel[2];
  longint     m_g[2];

  typedef struct {
    logic        rst;
    logic [2:0]  sens;
    logic [2:0]  sw;
    logic [31:0] g;
  } vec_t;

  vec_t tbl[8];

  exp_42 #(.MIN_HOLD(HOLD_A), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst(rst),
    .sensor1(sens[0]), .sensor2(sens[1]), .sensor3(sens[2]),
    .switch1(sw1a), .switch2(sw2a), .switch3(sw3a), .g(ga)
  );

  exp_42 #(.MIN_HOLD(HOLD_B), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst),
    .sensor1(sens[0]), .sensor2(sens[1]), .sensor3(sens[2]),
    .switch1(sw1b), .switch2(sw2b), .switch3(sw3b), .g(gb)
  );

  assign swa = {sw3a, sw2a, sw1a};
  assign swb = {sw3b, sw2b, sw1b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] sel2sw(input int sel);
    case (sel)
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_edge();
    logic [2:0] syn;
    int req;
    int h;
    if (!rst) begin
      m_q = {};
      for (int i = 0; i < SYNC; i++) m_q.push_back(3'b000);
      for (int k = 0; k < 2; k++) begin
        m_sel[k] = 0;
        m_g[k]   = 0;
      end
    end else begin
      syn = m_q.pop_front();
      m_q.push_back(sens);
      req = syn[0] ? 1 : syn[1] ? 2 : syn[2] ? 3 : 0;
      for (int k = 0; k < 2; k++) begin
        h = (k == 0) ? HOLD_A : HOLD_B;
        if ((m_sel[k] == 0 && req != 0) ||
            (m_sel[k] != 0 && req != m_sel[k] && m_g[k] >= h)) begin
          m_sel[k] = req;
          m_g[k]   = 0;
        end else if (m_g[k] < 64'hFFFF_FFFF) begin
          m_g[k] = m_g[k] + 1;
        end
      end
    end
  endtask

  // One rising edge: advance the model at the edge, compare just after.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("A_sw", {29'd0, swa}, {29'd0, sel2sw(m_sel[0])});
    check("A_g", ga, m_g[0][31:0]);
    check("B_sw", {29'd0, swb}, {29'd0, sel2sw(m_sel[1])});
    check("B_g", gb, m_g[1][31:0]);
    check("B_onehot0", {31'd0, $onehot0(swb)}, 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b0;
    sens = 3'b000;
    for (int i = 0; i < SYNC; i++) m_q.push_back(3'b000);
    m_sel[0] = 0; m_sel[1] = 0;
    m_g[0] = 0;   m_g[1] = 0;

    // Reset, then sensor1 alone: switch1 on the 3rd edge, g counts from 0.
    tbl[0] = '{1'b0, 3'b000, 3'b000, 32'd0};
    tbl[1] = '{1'b0, 3'b000, 3'b000, 32'd0};
    tbl[2] = '{1'b1, 3'b001, 3'b000, 32'd1};
    tbl[3] = '{1'b1, 3'b001, 3'b000, 32'd2};
    tbl[4] = '{1'b1, 3'b001, 3'b001, 32'd0};
    tbl[5] = '{1'b1, 3'b001, 3'b001, 32'd1};
    tbl[6] = '{1'b1, 3'b001, 3'b001, 32'd2};
    tbl[7] = '{1'b1, 3'b001, 3'b001, 32'd3};

    for (int i = 0; i < 8; i++) begin
      rst  = tbl[i].rst;
      sens = tbl[i].sens;
      tick();
      check("tbl_sw", {29'd0, swa}, {29'd0, tbl[i].sw});
      check("tbl_g", ga, tbl[i].g);
    end

    // SEL1 held past g>20; a lower-priority request alone changes nothing.
    ticks(20);
    check("sel1_g23", ga, 32'd23);
    sens = 3'b011;
    ticks(3);
    check("sel1_keep_sw", {29'd0, swa}, 32'b001);
    check("sel1_keep_g", ga, 32'd26);
    sens = 3'b010;
    ticks(2);
    check("s1fall_e2_sw", {29'd0, swa}, 32'b001);
    tick();
    check("s1fall_e3_sw", {29'd0, swa}, 32'b010);
    check("s1fall_e3_g", ga, 32'd0);

    // SEL2, sensor2 falls at g=3: held until g=10, then IDLE.
    ticks(3);
    check("sel2_g3", ga, 32'd3);
    sens = 3'b000;
    ticks(7);
    check("sel2_hold_sw", {29'd0, swa}, 32'b010);
    check("sel2_hold_g", ga, 32'd10);
    tick();
    check("sel2_idle_sw", {29'd0, swa}, 32'b000);
    check("sel2_idle_g", ga, 32'd0);

    // All sensors together: priority picks route 1; then route 3 after hold.
    sens = 3'b111;
    ticks(3);
    check("all_sw", {29'd0, swa}, 32'b001);
    check("all_g", ga, 32'd0);
    ticks(10);
    sens = 3'b100;
    ticks(2);
    check("drop12_e2_sw", {29'd0, swa}, 32'b001);
    tick();
    check("drop12_e3_sw", {29'd0, swa}, 32'b100);
    check("drop12_e3_g", ga, 32'd0);

    // Reset mid-hold in SEL3 at g=7, sensor3 still high.
    ticks(7);
    check("sel3_g7", ga, 32'd7);
    rst = 1'b0;
    tick();
    check("rst_sw", {29'd0, swa}, 32'b000);
    check("rst_g", ga, 32'd0);
    rst = 1'b1;
    ticks(2);
    check("post_rst_e2_sw", {29'd0, swa}, 32'b000);
    tick();
    check("post_rst_e3_sw", {29'd0, swa}, 32'b100);
    check("post_rst_e3_g", ga, 32'd0);

    // Randomized run against the model, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 5) == 0) sens[$urandom_range(0, 2)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) sens = 3'($urandom_range(0, 7));
      tick();
      check("A_onehot0", {31'd0, $onehot0(swa)}, 32'd1);
    end
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
